// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory bus: request from the core (master), response from memory (slave).
interface picorv32_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Word-addressed memory answering PicoRV32 native requests with fixed or stall-driven latency,
// plus sticky error flags and a transaction counter.
module picorv32_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned MODE       = 1,
  parameter int unsigned FIXED_LAT  = 0,
  parameter int unsigned MAX_WAIT   = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  picorv32_mem_responder_if.slave bus,
  input  logic                  stall_req,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_data,
  output logic                  oob_err,
  output logic                  protocol_err,
  output logic                  timeout_hit,
  output logic [15:0]           txn_count
);

  localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [7:0]  FIXED_LAT_C = 8'(FIXED_LAT);
  localparam logic [7:0]  MAX_WAIT_C  = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [7:0]              wait_cnt_r, wait_cnt_nxt_s;
  logic [31:0]             addr_r, wdata_r, rdata_r;
  logic [3:0]              wstrb_r;
  logic                    ready_r, oob_err_r, protocol_err_r, timeout_hit_r;
  logic [15:0]             txn_count_r;
  logic [31:0]             eff_addr_s, eff_wdata_s, offset_s;
  logic [3:0]              eff_wstrb_s;
  logic [DEPTH_LOG2-1:0]   index_s;
  logic                    in_range_s, enter_resp_s, timeout_s;
  logic                    proto_viol_s, init_ok_s, do_write_s;
  logic                    unused_s;
  logic [31:0]             mem_r [DEPTH];

  assign unused_s = bus.mem_instr;

  // Live bus values in IDLE, captured values once the request is pending.
  always_comb begin
    if (state_r == S_IDLE) begin
      eff_addr_s  = bus.mem_addr;
      eff_wdata_s = bus.mem_wdata;
      eff_wstrb_s = bus.mem_wstrb;
    end else begin
      eff_addr_s  = addr_r;
      eff_wdata_s = wdata_r;
      eff_wstrb_s = wstrb_r;
    end
    offset_s   = eff_addr_s - BASE_ADDR;
    index_s    = offset_s[DEPTH_LOG2+1:2];
    in_range_s = (eff_addr_s >= BASE_ADDR) && ((offset_s >> (DEPTH_LOG2 + 2)) == 32'd0)
                 && (eff_addr_s[1:0] == 2'b00);
  end

  // Next-state and wait counter.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = 8'd0;
    timeout_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!bus.mem_valid) begin
          state_nxt_s = S_IDLE;
        end else if ((MODE == 32'd0) ? (FIXED_LAT == 32'd0) : !stall_req) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s    = S_WAIT;
          wait_cnt_nxt_s = 8'd1;
        end
      end
      S_WAIT: begin
        if (MODE == 32'd0) begin
          if (wait_cnt_r == FIXED_LAT_C) begin
            state_nxt_s = S_RESP;
          end else begin
            state_nxt_s    = S_WAIT;
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
          end
        end else if (!stall_req) begin
          state_nxt_s = S_RESP;
        end else if (wait_cnt_r == MAX_WAIT_C) begin
          state_nxt_s = S_RESP;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s    = S_WAIT;
          wait_cnt_nxt_s = wait_cnt_r + 8'd1;
        end
      end
      S_RESP:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  assign enter_resp_s = (state_nxt_s == S_RESP);
  assign proto_viol_s = (state_r == S_WAIT) &&
                        (!bus.mem_valid || (bus.mem_addr != addr_r) ||
                         (bus.mem_wdata != wdata_r) || (bus.mem_wstrb != wstrb_r));
  assign init_ok_s    = init_we && (state_r == S_IDLE) && !bus.mem_valid;
  assign do_write_s   = enter_resp_s && in_range_s && (eff_wstrb_s != 4'b0000);

  // Control, response and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= S_IDLE;
      wait_cnt_r     <= 8'd0;
      addr_r         <= 32'd0;
      wdata_r        <= 32'd0;
      wstrb_r        <= 4'd0;
      ready_r        <= 1'b0;
      rdata_r        <= 32'd0;
      oob_err_r      <= 1'b0;
      protocol_err_r <= 1'b0;
      timeout_hit_r  <= 1'b0;
      txn_count_r    <= 16'd0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      ready_r       <= enter_resp_s;
      timeout_hit_r <= timeout_s;
      if ((state_r == S_IDLE) && bus.mem_valid) begin
        addr_r  <= bus.mem_addr;
        wdata_r <= bus.mem_wdata;
        wstrb_r <= bus.mem_wstrb;
      end
      // Read data lives only for the single RESP cycle.
      if (enter_resp_s && in_range_s && (eff_wstrb_s == 4'b0000)) begin
        rdata_r <= mem_r[index_s];
      end else begin
        rdata_r <= 32'd0;
      end
      if (enter_resp_s && !in_range_s) begin
        oob_err_r <= 1'b1;
      end
      if (proto_viol_s) begin
        protocol_err_r <= 1'b1;
      end
      if (state_r == S_RESP) begin
        txn_count_r <= txn_count_r + 16'd1;
      end
    end
  end

  // Storage is deliberately never reset; preload and byte-lane writes only.
  always_ff @(posedge clk) begin
    if (init_ok_s) begin
      mem_r[init_addr] <= init_data;
    end else if (do_write_s) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_wstrb_s[i]) begin
          mem_r[index_s][8*i +: 8] <= eff_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_ready = ready_r;
  assign bus.mem_rdata = rdata_r;
  assign oob_err       = oob_err_r;
  assign protocol_err  = protocol_err_r;
  assign timeout_hit   = timeout_hit_r;
  assign txn_count     = txn_count_r;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench: three responder configurations share one stimulus bus, gated by sel.
module tb_picorv32_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        stall_req;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [31:0] init_data;
  logic [1:0]  sel;

  logic [2:0]  oob_v, perr_v, tmo_v;
  logic [15:0] cnt0, cnt1, cnt2;
  logic        rdy_s, oob_s, perr_s, tmo_s;
  logic [31:0] rdata_s;
  logic [15:0] cnt_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  picorv32_mem_responder_if if0 ();
  picorv32_mem_responder_if if1 ();
  picorv32_mem_responder_if if2 ();

  assign if0.mem_valid = req_valid && (sel == 2'd0);
  assign if1.mem_valid = req_valid && (sel == 2'd1);
  assign if2.mem_valid = req_valid && (sel == 2'd2);
  assign if0.mem_instr = 1'b0;
  assign if1.mem_instr = 1'b0;
  assign if2.mem_instr = 1'b0;
  assign if0.mem_addr  = req_addr;
  assign if1.mem_addr  = req_addr;
  assign if2.mem_addr  = req_addr;
  assign if0.mem_wdata = req_wdata;
  assign if1.mem_wdata = req_wdata;
  assign if2.mem_wdata = req_wdata;
  assign if0.mem_wstrb = req_wstrb;
  assign if1.mem_wstrb = req_wstrb;
  assign if2.mem_wstrb = req_wstrb;

  picorv32_mem_responder #(.MODE(0), .FIXED_LAT(0)) u_fix0 (
    .clk(clk), .resetn(resetn), .bus(if0), .stall_req(stall_req),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .oob_err(oob_v[0]), .protocol_err(perr_v[0]), .timeout_hit(tmo_v[0]), .txn_count(cnt0));

  picorv32_mem_responder #(.MODE(0), .FIXED_LAT(3)) u_fix3 (
    .clk(clk), .resetn(resetn), .bus(if1), .stall_req(stall_req),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .oob_err(oob_v[1]), .protocol_err(perr_v[1]), .timeout_hit(tmo_v[1]), .txn_count(cnt1));

  picorv32_mem_responder #(.MODE(1), .MAX_WAIT(10)) u_stall (
    .clk(clk), .resetn(resetn), .bus(if2), .stall_req(stall_req),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .oob_err(oob_v[2]), .protocol_err(perr_v[2]), .timeout_hit(tmo_v[2]), .txn_count(cnt2));

  always_comb begin
    case (sel)
      2'd0:    begin rdy_s = if0.mem_ready; rdata_s = if0.mem_rdata; cnt_s = cnt0; end
      2'd1:    begin rdy_s = if1.mem_ready; rdata_s = if1.mem_rdata; cnt_s = cnt1; end
      default: begin rdy_s = if2.mem_ready; rdata_s = if2.mem_rdata; cnt_s = cnt2; end
    endcase
    oob_s  = oob_v[sel];
    perr_s = perr_v[sel];
    tmo_s  = tmo_v[sel];
  end

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          nstall;
    int          lat;
    logic [31:0] rdata;
    logic        oob;
    int          tmo;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    tick();
    init_we   = 1'b0;
  endtask

  // One request held until mem_ready; lat counts cycles from valid to ready.
  task automatic do_txn(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int nstall, output int lat,
                        output int tmo_cnt, output logic [31:0] rd, output logic oob);
    logic got;
    sel       = s;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = ws;
    req_valid = 1'b1;
    stall_req = (nstall > 0);
    lat = 0; tmo_cnt = 0; got = 1'b0; rd = 32'hXXXX_XXXX; oob = 1'bx;
    while (!got && lat < 40) begin
      tick();
      lat++;
      stall_req = (lat < nstall);
      if (tmo_s) tmo_cnt++;
      if (rdy_s) begin
        got = 1'b1;
        rd  = rdata_s;
        oob = oob_s;
      end
    end
    req_valid = 1'b0;
    stall_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, tmo;
    logic [31:0] rd;
    logic        oob, saw_rdy;

    resetn = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_wstrb = 4'd0; stall_req = 1'b0; init_we = 1'b0; init_addr = 8'd0;
    init_data = 32'd0; sel = 2'd0;

    vt[0]  = '{2'd0, 32'h0000_000C, 32'h0,          4'b0000, 0,  1,  32'hDEAD_BEEF, 1'b0, 0, 16'd1};
    vt[1]  = '{2'd1, 32'h0000_0010, 32'h1122_3344,  4'b0101, 0,  4,  32'h0,         1'b0, 0, 16'd1};
    vt[2]  = '{2'd1, 32'h0000_0010, 32'h0,          4'b0000, 5,  4,  32'hAA22_AA44, 1'b0, 0, 16'd2};
    vt[3]  = '{2'd2, 32'h0000_0014, 32'h0,          4'b0000, 99, 11, 32'h1234_5678, 1'b0, 1, 16'd1};
    vt[4]  = '{2'd2, 32'h0000_000C, 32'h0,          4'b0000, 2,  3,  32'hDEAD_BEEF, 1'b0, 0, 16'd2};
    vt[5]  = '{2'd2, 32'h0000_0014, 32'hFFEE_DDCC,  4'b1000, 0,  1,  32'h0,         1'b0, 0, 16'd3};
    vt[6]  = '{2'd2, 32'h0000_0014, 32'h0,          4'b0000, 0,  1,  32'hFF34_5678, 1'b0, 0, 16'd4};
    vt[7]  = '{2'd2, 32'h0000_03FC, 32'h0,          4'b0000, 0,  1,  32'hCAFE_F00D, 1'b0, 0, 16'd5};
    vt[8]  = '{2'd2, 32'h0000_0400, 32'h0,          4'b0000, 0,  1,  32'h0,         1'b1, 0, 16'd6};
    vt[9]  = '{2'd2, 32'h0000_0002, 32'h0,          4'b0000, 0,  1,  32'h0,         1'b1, 0, 16'd7};
    vt[10] = '{2'd2, 32'h0000_0400, 32'h0,          4'b1111, 0,  1,  32'h0,         1'b1, 0, 16'd8};
    vt[11] = '{2'd2, 32'h0000_0000, 32'h0,          4'b0000, 0,  1,  32'h5555_0000, 1'b1, 0, 16'd9};
    vt[12] = '{2'd2, 32'h0000_0002, 32'h0,          4'b1111, 3,  4,  32'h0,         1'b1, 0, 16'd10};
    vt[13] = '{2'd2, 32'h0000_0000, 32'h0,          4'b0000, 0,  1,  32'h5555_0000, 1'b1, 0, 16'd11};

    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset_flags[%0d]", s), {28'd0, rdy_s, oob_s, perr_s, tmo_s}, 32'd0);
      check($sformatf("reset_rdata[%0d]", s), rdata_s, 32'd0);
      check($sformatf("reset_cnt[%0d]", s), {16'd0, cnt_s}, 32'd0);
    end
    resetn = 1'b1;
    tick();

    preload(8'd0,   32'h5555_0000);
    preload(8'd3,   32'hDEAD_BEEF);
    preload(8'd4,   32'hAAAA_AAAA);
    preload(8'd5,   32'h1234_5678);
    preload(8'd255, 32'hCAFE_F00D);

    for (int i = 0; i < NV; i++) begin
      do_txn(vt[i].sel, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].nstall, lat, tmo, rd, oob);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      check($sformatf("v%0d_oob", i), {31'd0, oob}, {31'd0, vt[i].oob});
      check($sformatf("v%0d_timeout", i), 32'(tmo), 32'(vt[i].tmo));
      tick();
      check($sformatf("v%0d_release", i), {31'd0, rdy_s} | rdata_s | {31'd0, tmo_s}, 32'd0);
      check($sformatf("v%0d_count", i), {16'd0, cnt_s}, {16'd0, vt[i].cnt});
      check($sformatf("v%0d_perr", i), {31'd0, perr_s}, 32'd0);
    end

    // Address changes while the stall-driven request waits.
    sel = 2'd2; req_addr = 32'h0000_000C; req_wdata = 32'd0; req_wstrb = 4'd0;
    req_valid = 1'b1; stall_req = 1'b1;
    tick();
    tick();
    req_addr = 32'h0000_0014;
    tick();
    stall_req = 1'b0;
    lat = 0; rd = 32'd0;
    while (!rdy_s && lat < 20) begin
      tick();
      lat++;
    end
    rd = rdata_s;
    req_valid = 1'b0;
    check("proto_ready_seen", {31'd0, rdy_s}, 32'd1);
    check("proto_captured_rdata", rd, 32'hDEAD_BEEF);
    tick();
    check("proto_err_sticky", {31'd0, perr_s}, 32'd1);
    check("proto_oob_sticky", {31'd0, oob_s}, 32'd1);

    // Reset while a write is waiting must abandon it.
    sel = 2'd1; req_addr = 32'h0000_000C; req_wdata = 32'h0000_0000; req_wstrb = 4'b1111;
    req_valid = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    req_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rst_flags[%0d]", s), {28'd0, rdy_s, oob_s, perr_s, tmo_s}, 32'd0);
      check($sformatf("rst_cnt[%0d]", s), {16'd0, cnt_s}, 32'd0);
    end
    sel = 2'd1;
    saw_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rdy_s) saw_rdy = 1'b1;
    end
    resetn = 1'b1;
    do_txn(2'd0, 32'h0000_000C, 32'd0, 4'b0000, 0, lat, tmo, rd, oob);
    check("post_rst_first_latency", 32'(lat), 32'd1);
    tick();
    do_txn(2'd1, 32'h0000_000C, 32'd0, 4'b0000, 0, lat, tmo, rd, oob);
    check("rst_no_ready", {31'd0, saw_rdy}, 32'd0);
    check("rst_word_kept", rd, 32'hDEAD_BEEF);
    check("post_rst_latency", 32'(lat), 32'd4);
    tick();
    check("post_rst_count", {16'd0, cnt_s}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_responder.md
PICORV32_MEM_RESPONDER -- requirements
Module: picorv32_mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: memory holds 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; SHALL be word-aligned.
REQ-003 Parameter MODE, default 1: 0 = fixed latency, 1 = stall-driven latency.
REQ-004 Parameter FIXED_LAT, default 0, range 0..255: wait cycles in MODE 0.
REQ-005 Parameter MAX_WAIT, default 10, range 1..255: wait-cycle cap in MODE 1.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 resetn  in  1  asynchronous, active-low reset.
REQ-008 mem_valid  in  1  PicoRV32 native request valid.
REQ-009 mem_instr  in  1  request is an instruction fetch (informational).
REQ-010 mem_addr  in  32  byte address.
REQ-011 mem_wdata  in  32  write data.
REQ-012 mem_wstrb  in  4  byte write strobes; 0 = read.
REQ-013 mem_ready  out  1  registered response strobe.
REQ-014 mem_rdata  out  32  registered read data.
REQ-015 stall_req  in  1  latency control in MODE 1 (bench- or anyseq-driven).
REQ-016 init_we, init_addr[DEPTH_LOG2-1:0], init_data[31:0]  in  preload port.
REQ-017 oob_err  out  1  sticky: out-of-range or misaligned access seen.
REQ-018 protocol_err  out  1  sticky: request changed or dropped while pending.
REQ-019 timeout_hit  out  1  one-cycle pulse when MAX_WAIT forced a response.
REQ-020 txn_count  out  16  completed transactions, wraps 16'hFFFF -> 0.

Function
REQ-021 FSM states: IDLE, WAIT, RESP; mem_ready SHALL equal (state == RESP), high exactly one cycle per transaction.
REQ-022 IDLE with mem_valid: capture addr/wdata/wstrb; go RESP if done-condition already met (MODE 0: FIXED_LAT==0; MODE 1: !stall_req), else WAIT with wait_cnt=1.
REQ-023 WAIT: go RESP when MODE 0: wait_cnt==FIXED_LAT; MODE 1: !stall_req or wait_cnt==MAX_WAIT; else wait_cnt++.
REQ-024 timeout_hit SHALL pulse on the WAIT->RESP edge when MODE 1, stall_req high, wait_cnt==MAX_WAIT.
REQ-025 Latency: valid first sampled in cycle c -> mem_ready in cycle c+1+W, W = number of WAIT cycles (MODE 0: FIXED_LAT; MODE 1: min(consecutive stall_req highs from cycle c, MAX_WAIT)).
REQ-026 RESP -> IDLE unconditionally; at least one IDLE cycle between transactions.
REQ-027 Word index = (addr - BASE_ADDR) >> 2; in range iff index < 2**DEPTH_LOG2 and addr >= BASE_ADDR.
REQ-028 Read (wstrb==0), in range, aligned: mem_rdata = word, loaded on the edge entering RESP.
REQ-029 Write: each lane i with wstrb[i] set SHALL update byte i on the edge entering RESP; other lanes unchanged; mem_rdata = 0.
REQ-030 Out-of-range or addr[1:0]!=0: no write, mem_rdata = 0, oob_err set; mem_ready still given per REQ-025.
REQ-031 mem_rdata SHALL return to 0 on the edge leaving RESP.
REQ-032 In WAIT: mem_valid low, or addr/wdata/wstrb differing from captured values, SHALL set protocol_err; transaction completes with captured values.
REQ-033 init_we honoured only in IDLE with mem_valid low; writes full word init_data at init_addr; otherwise ignored.
REQ-034 txn_count increments on every RESP cycle.
REQ-035 Memory contents SHALL NOT be reset; undefined until written or preloaded.

Reset
REQ-036 resetn low SHALL immediately force: state IDLE, mem_ready 0, mem_rdata 0, wait_cnt 0, oob_err 0, protocol_err 0, timeout_hit 0, txn_count 0.
REQ-037 Reset during WAIT abandons the transaction: no memory write, no mem_ready.
REQ-038 First request accepted on the first rising edge with resetn high.

Verification
REQ-039 MODE 0, FIXED_LAT 0: preload word 3 = 32'hDEAD_BEEF; read addr 0x0C -> mem_ready one cycle after valid sampled, mem_rdata 32'hDEAD_BEEF, txn_count 1.
REQ-040 MODE 0, FIXED_LAT 3: write 32'h1122_3344 wstrb 4'b0101 to addr 0x10 over word 32'hAAAA_AAAA -> ready in cycle c+4; read back 32'hAA22_AA44.
REQ-041 MODE 1, MAX_WAIT 10, stall_req held high -> ready in cycle c+11, timeout_hit pulses once; stall_req low after 2 cycles -> ready c+3, no pulse.
REQ-042 Read 0x400 with DEPTH_LOG2 8, then read 0x02 -> mem_rdata 0, oob_err 1 and sticky, memory unchanged.
REQ-043 Change mem_addr during WAIT -> protocol_err 1, response uses captured address; assert resetn low in WAIT of a write -> mem_ready never rises, target word unchanged, all flags 0.
